result_bcd_display: RTL and testbench

RESULT_BCD_DISPLAY -- requirements
Module: result_bcd_display

---
 rtl/result_bcd_display_pkg.sv | 24 ++
 rtl/result_bcd_display_if.sv | 17 +
 rtl/result_bcd_display_seg7_decoder.sv | 23 ++
 rtl/result_bcd_display.sv | 85 ++++++++
 tb/tb_result_bcd_display.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/result_bcd_display_pkg.sv
// result_bcd_display_pkg: shared FSM states, segment patterns and double-dabble step
package result_bcd_display_pkg;
  typedef enum logic {IDLE, CONVERT} state_t;
  localparam int REFRESH_DIV_DEFAULT = 16;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Nibbles sit at [18:15] hundreds, [14:11] tens, [10:7] ones; binary in [6:0].
  function automatic logic [18:0] dd_step(input logic [18:0] s);
    logic [18:0] a;
    a = s;
    for (int i = 0; i < 3; i++)
      if (a[7+4*i +: 4] >= 4'd5) a[7+4*i +: 4] = a[7+4*i +: 4] + 4'd3;
    return {a[17:0], 1'b0};
  endfunction
endpackage

// File: rtl/result_bcd_display_if.sv
// result_bcd_display_if: upstream result handshake plus BCD and display outputs
interface result_bcd_display_if;
  logic [6:0] result;
  logic       done;
  logic       busy;
  logic       bcd_valid;
  logic [3:0] bcd_hundreds;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       overrun;
  logic [6:0] seg;
  logic [2:0] an;
  modport master (output result, done,
                  input busy, bcd_valid, bcd_hundreds, bcd_tens, bcd_ones, overrun, seg, an);
  modport slave (input result, done,
                 output busy, bcd_valid, bcd_hundreds, bcd_tens, bcd_ones, overrun, seg, an);
endinterface

// File: rtl/result_bcd_display_seg7_decoder.sv
// seg7_decoder: BCD digit to active-low {g,f,e,d,c,b,a}; codes above 9 render blank
module seg7_decoder
  import result_bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/result_bcd_display.sv
// result_bcd_display: 7-bit result to BCD via double-dabble, multiplexed onto a 3-digit display
module result_bcd_display
  import result_bcd_display_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input logic clk,
  input logic reset_n,
  result_bcd_display_if.slave bus
);
  state_t state, state_n;
  logic [18:0] sr, sr_step;
  logic [2:0] cnt;
  logic bcd_valid, overrun;
  logic [3:0] hun, ten, one;
  logic [15:0] rcnt;
  logic [1:0] idx, idx_n;
  logic [2:0] an;
  logic [3:0] digit;
  logic wrap;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (bus.done ? CONVERT : IDLE) : (cnt == 3'd6 ? IDLE : CONVERT);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  assign sr_step = dd_step(sr);
  // The seventh shift lands the finished digits, so they load straight from sr_step.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr <= '0;
      cnt <= '0;
      bcd_valid <= 1'b0;
      overrun <= 1'b0;
      hun <= '0;
      ten <= '0;
      one <= '0;
    end else begin
      bcd_valid <= 1'b0;
      if (state == IDLE && bus.done) begin
        sr <= {12'b0, bus.result};
        cnt <= '0;
        overrun <= 1'b0;
      end else if (state == CONVERT) begin
        sr <= sr_step;
        cnt <= cnt + 3'd1;
        if (bus.done) overrun <= 1'b1;
        if (cnt == 3'd6) begin
          hun <= sr_step[18:15];
          ten <= sr_step[14:11];
          one <= sr_step[10:7];
          bcd_valid <= 1'b1;
        end
      end
    end
  end
  assign wrap = rcnt == 16'(REFRESH_DIV - 1);
  assign idx_n = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rcnt <= '0;
      idx <= '0;
      an <= 3'b110;
    end else begin
      rcnt <= wrap ? 16'd0 : rcnt + 16'd1;
      if (wrap) begin
        idx <= idx_n;
        an <= ~(3'b001 << idx_n);
      end
    end
  end
  // Code 4'hF is out of BCD range and decodes to a blank digit.
  assign digit = (idx == 2'd2) ? ((hun == 4'd0) ? 4'hF : hun) :
                 (idx == 2'd1) ? ((hun == 4'd0 && ten == 4'd0) ? 4'hF : ten) : one;
  seg7_decoder u_dec (.bcd(digit), .seg(bus.seg));
  assign bus.busy = state == CONVERT;
  assign bus.bcd_valid = bcd_valid;
  assign bus.overrun = overrun;
  assign bus.bcd_hundreds = hun;
  assign bus.bcd_tens = ten;
  assign bus.bcd_ones = one;
  assign bus.an = an;
endmodule

// File: tb/tb_result_bcd_display.sv
// tb_result_bcd_display: directed checks of conversion latency, overrun, blanking and refresh
module tb_result_bcd_display;
  logic clk = 1'b0;
  logic reset_n;
  int pass_cnt = 0;
  int total = 0;
  result_bcd_display_if bus();
  result_bcd_display #(.REFRESH_DIV(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic convert(input logic [6:0] r, output bit ok);
    ok = 1'b0;
    bus.result = r;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      ok = bus.bcd_valid;
    end
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    bus.done = 1'b0;
    bus.result = '0;
    tick();
    tick();
    total++; if ({bus.busy, bus.bcd_valid, bus.overrun} !== 3'b000) $display("FAIL reset_flags got %b want 000", {bus.busy, bus.bcd_valid, bus.overrun}); else pass_cnt++;
    total++; if ({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones} !== 12'h000) $display("FAIL reset_bcd got %h want 000", {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}); else pass_cnt++;
    total++; if (bus.an !== 3'b110) $display("FAIL reset_an got %b want 110", bus.an); else pass_cnt++;
    total++; if (bus.seg !== 7'b1000000) $display("FAIL reset_seg got %b want 1000000", bus.seg); else pass_cnt++;
    reset_n = 1'b1;
    tick();
  endtask
  task automatic test_convert_120();
    int busy_cycles = 0;
    int early_valid = 0;
    bus.result = 7'd120;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    for (int i = 0; i < 7; i++) begin
      busy_cycles += int'(bus.busy);
      early_valid += int'(bus.bcd_valid);
      tick();
    end
    total++; if (busy_cycles !== 7) $display("FAIL c120_busy_cycles got %0d want 7", busy_cycles); else pass_cnt++;
    total++; if (early_valid !== 0) $display("FAIL c120_early_valid got %0d want 0", early_valid); else pass_cnt++;
    total++; if ({bus.busy, bus.bcd_valid} !== 2'b01) $display("FAIL c120_done_edge busy/valid got %b want 01", {bus.busy, bus.bcd_valid}); else pass_cnt++;
    total++; if ({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones} !== 12'h120) $display("FAIL c120_digits got %h want 120", {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}); else pass_cnt++;
    tick();
    total++; if (bus.bcd_valid !== 1'b0) $display("FAIL c120_valid_pulse got %b want 0", bus.bcd_valid); else pass_cnt++;
  endtask
  task automatic test_blank_7();
    bit ok;
    int bad = 0;
    logic [6:0] want;
    convert(7'd7, ok);
    total++; if (!ok) $display("FAIL c7_timeout got no bcd_valid want pulse"); else pass_cnt++;
    total++; if ({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones} !== 12'h007) $display("FAIL c7_digits got %h want 007", {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}); else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      want = (bus.an == 3'b110) ? 7'b1111000 : 7'h7F;
      if (bus.seg !== want || !(bus.an inside {3'b110, 3'b101, 3'b011})) begin
        bad++;
        $display("FAIL c7_seg an=%b got %b want %b", bus.an, bus.seg, want);
      end
      tick();
    end
    total++; if (bad !== 0) $display("FAIL c7_round got %0d bad cycles want 0", bad); else pass_cnt++;
  endtask
  task automatic test_overrun_127();
    bit ok;
    bus.result = 7'd127;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    tick();
    bus.result = 7'd5;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    total++; if ({bus.busy, bus.overrun} !== 2'b11) $display("FAIL ovr_set busy/overrun got %b want 11", {bus.busy, bus.overrun}); else pass_cnt++;
    for (int i = 0; i < 4; i++) tick();
    total++; if (bus.bcd_valid !== 1'b1) $display("FAIL ovr_latency valid got %b want 1", bus.bcd_valid); else pass_cnt++;
    total++; if ({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones} !== 12'h127) $display("FAIL ovr_digits got %h want 127", {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}); else pass_cnt++;
    total++; if (bus.overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", bus.overrun); else pass_cnt++;
    bus.result = 7'd3;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    total++; if ({bus.busy, bus.overrun} !== 2'b10) $display("FAIL ovr_clear busy/overrun got %b want 10", {bus.busy, bus.overrun}); else pass_cnt++;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      ok = bus.bcd_valid;
    end
    total++; if (!ok || {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones} !== 12'h003) $display("FAIL b2b_digits got %h ok=%b want 003", {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}, ok); else pass_cnt++;
  endtask
  task automatic test_refresh_0();
    bit ok;
    int k;
    int bad = 0;
    logic [2:0] prev;
    logic [2:0] seq [3];
    logic [2:0] want_an;
    logic [6:0] want_seg;
    seq[0] = 3'b110;
    seq[1] = 3'b101;
    seq[2] = 3'b011;
    convert(7'd0, ok);
    total++; if (!ok || {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones} !== 12'h000) $display("FAIL r0_digits got %h ok=%b want 000", {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}, ok); else pass_cnt++;
    prev = bus.an;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      ok = bus.an !== prev;
    end
    total++; if (!ok) $display("FAIL r0_sync got an stuck at %b want change", bus.an); else pass_cnt++;
    k = (bus.an == 3'b110) ? 0 : (bus.an == 3'b101) ? 1 : 2;
    for (int j = 0; j < 24; j++) begin
      want_an = seq[(k + j / 4) % 3];
      want_seg = (want_an == 3'b110) ? 7'b1000000 : 7'h7F;
      if (bus.an !== want_an || bus.seg !== want_seg) begin
        bad++;
        $display("FAIL r0_cycle%0d an/seg got %b/%b want %b/%b", j, bus.an, bus.seg, want_an, want_seg);
      end
      tick();
    end
    total++; if (bad !== 0) $display("FAIL r0_sequence got %0d bad cycles want 0", bad); else pass_cnt++;
  endtask
  task automatic test_reset_abort();
    bit ok;
    int pulses = 0;
    bus.result = 7'd99;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    total++; if ({bus.busy, bus.bcd_valid, bus.overrun} !== 3'b000) $display("FAIL abort_flags got %b want 000", {bus.busy, bus.bcd_valid, bus.overrun}); else pass_cnt++;
    total++; if ({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones, bus.an, bus.seg} !== {12'h000, 3'b110, 7'b1000000}) $display("FAIL abort_outputs got %h/%b/%b want 000/110/1000000", {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}, bus.an, bus.seg); else pass_cnt++;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pulses += int'(bus.bcd_valid);
      tick();
    end
    total++; if (pulses !== 0 || {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones} !== 12'h000) $display("FAIL abort_quiet got %0d pulses digits %h want 0/000", pulses, {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}); else pass_cnt++;
    convert(7'd45, ok);
    total++; if (!ok || {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones} !== 12'h045) $display("FAIL abort_next got %h ok=%b want 045", {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}, ok); else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_convert_120();
    test_blank_7();
    test_overrun_127();
    test_refresh_0();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
